// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: sweep FSM encoding and default widths.
// Pure declarations, no logic.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, updated on clk rise.
// Lookups are combinational; no backpressure, set/clear are sampled every cycle when enabled.
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              set_vld_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_vld_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set is applied after clear so a same-address issue (newer producer) wins.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else if (en_i) begin
      if (clr_vld_i) busy_d[clr_addr_i] = 1'b0;
      if (set_vld_i && !(ZERO_REG && set_addr_i == '0)) busy_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    busy1_o = busy_q[rd_addr1_i];
    busy2_o = busy_q[rd_addr2_i];
    if (BYPASS && clr_vld_i && clr_addr_i == rd_addr1_i) busy1_o = 1'b0;
    if (BYPASS && clr_vld_i && clr_addr_i == rd_addr2_i) busy2_o = 1'b0;
    if (ZERO_REG && rd_addr1_i == '0) busy1_o = 1'b0;
    if (ZERO_REG && rd_addr2_i == '0) busy2_o = 1'b0;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file, 2 async read / 1 sync write, with write bypass, busy scoreboard and clear sweep.
// Reads are combinational; a clear sweep takes DEPTH cycles during which writes and issues are dropped.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              issueValid,
  input  logic [ADDR_W-1:0] issueAddr,
  output logic              busy1,
  output logic              busy2,
  input  logic              clearReq,
  output logic              clearBusy,
  output logic              clearDone
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              flush;
  logic              sweeping;
  logic              wr_en;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign sweeping  = (state_q == ST_SWEEP);
  assign clearBusy = sweeping;
  assign clearDone = (state_q == ST_DONE);
  assign wr_en     = regWrite && !sweeping && !(ZERO_REG && writeAddr == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clearReq) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
          flush   = 1'b1;
        end
      end
      ST_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the write port while active; writeback is dropped, not stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (sweeping) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[writeAddr] <= writeData;
    end
  end

  always_comb begin
    readData1 = mem_q[readAddr1];
    readData2 = mem_q[readAddr2];
    if (BYPASS && regWrite && !sweeping && writeAddr == readAddr1) readData1 = writeData;
    if (BYPASS && regWrite && !sweeping && writeAddr == readAddr2) readData2 = writeData;
    if (ZERO_REG && readAddr1 == '0) readData1 = '0;
    if (ZERO_REG && readAddr2 == '0) readData2 = '0;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .en_i      (!sweeping),
    .flush_i   (flush),
    .set_vld_i (issueValid),
    .set_addr_i(issueAddr),
    .clr_vld_i (regWrite),
    .clr_addr_i(writeAddr),
    .rd_addr1_i(readAddr1),
    .rd_addr2_i(readAddr2),
    .busy1_o   (busy1),
    .busy2_o   (busy2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32 instance plus a 16-bit, 8-entry instance.
module tb_regfile_sb;

  logic clk;
  logic reset;

  logic        regWrite, issueValid, clearReq;
  logic [4:0]  writeAddr, readAddr1, readAddr2, issueAddr;
  logic [31:0] writeData;
  logic [31:0] readData1, readData2;
  logic        busy1, busy2, clearBusy, clearDone;

  logic        s_regWrite, s_issueValid, s_clearReq;
  logic [2:0]  s_writeAddr, s_readAddr1, s_readAddr2, s_issueAddr;
  logic [15:0] s_writeData;
  logic [15:0] s_readData1, s_readData2;
  logic        s_busy1, s_busy2, s_clearBusy, s_clearDone;

  int nvec = 0;
  int nmis = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(readData1), .readData2(readData2),
    .issueValid(issueValid), .issueAddr(issueAddr),
    .busy1(busy1), .busy2(busy2),
    .clearReq(clearReq), .clearBusy(clearBusy), .clearDone(clearDone)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .regWrite(s_regWrite), .writeAddr(s_writeAddr), .writeData(s_writeData),
    .readAddr1(s_readAddr1), .readAddr2(s_readAddr2),
    .readData1(s_readData1), .readData2(s_readData2),
    .issueValid(s_issueValid), .issueAddr(s_issueAddr),
    .busy1(s_busy1), .busy2(s_busy2),
    .clearReq(s_clearReq), .clearBusy(s_clearBusy), .clearDone(s_clearDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    regWrite = 0; writeAddr = 0; writeData = 0; readAddr1 = 0; readAddr2 = 0;
    issueValid = 0; issueAddr = 0; clearReq = 0;
    s_regWrite = 0; s_writeAddr = 0; s_writeData = 0; s_readAddr1 = 0; s_readAddr2 = 0;
    s_issueValid = 0; s_issueAddr = 0; s_clearReq = 0;
    tick();
    readAddr1 = 5; readAddr2 = 7; s_readAddr1 = 3; s_readAddr2 = 7;
    #1;
    chk("rst_rd1", readData1, 32'h0);
    chk("rst_rd2", readData2, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_clrbusy", {31'b0, clearBusy}, 32'h0);
    chk("rst_clrdone", {31'b0, clearDone}, 32'h0);
    chk("rst_s_rd2", {16'h0, s_readData2}, 32'h0);
    chk("rst_s_busy", {30'b0, s_busy1, s_busy2}, 32'h0);
    reset = 1'b0;
    tick();

    // Write with same-cycle bypass, then stored value
    regWrite = 1; writeAddr = 5; writeData = 32'hDEADBEEF; readAddr1 = 5;
    #1 chk("byp_r5", readData1, 32'hDEADBEEF);
    tick();
    regWrite = 0;
    #1 chk("stored_r5", readData1, 32'hDEADBEEF);

    // Register zero
    regWrite = 1; writeAddr = 0; writeData = 32'h1234; readAddr1 = 0;
    #1 chk("r0_byp", readData1, 32'h0);
    tick();
    regWrite = 0; issueValid = 1; issueAddr = 0;
    tick();
    issueValid = 0;
    #1 chk("r0_rd", readData1, 32'h0);
    chk("r0_busy", {31'b0, busy1}, 32'h0);

    // Scoreboard set / same-edge set+clear / clear
    readAddr1 = 7; readAddr2 = 9; issueValid = 1; issueAddr = 7;
    #1 chk("busy7_pre", {31'b0, busy1}, 32'h0);
    tick();
    issueValid = 1; issueAddr = 9;
    #1 chk("busy7_set", {31'b0, busy1}, 32'h1);
    tick();
    issueValid = 1; issueAddr = 7; regWrite = 1; writeAddr = 7; writeData = 32'h77;
    #1 chk("busy9_set", {31'b0, busy2}, 32'h1);
    chk("busy7_wrbyp", {31'b0, busy1}, 32'h0);
    tick();
    issueValid = 0; regWrite = 0;
    #1 chk("busy7_setwins", {31'b0, busy1}, 32'h1);
    regWrite = 1; writeAddr = 7; writeData = 32'h78;
    #1 chk("busy7_clr_cyc", {31'b0, busy1}, 32'h0);
    tick();
    regWrite = 0;
    #1 chk("busy7_clr", {31'b0, busy1}, 32'h0);
    chk("rd7", readData1, 32'h78);

    // Asynchronous reset mid-operation
    readAddr1 = 5; readAddr2 = 9;
    #1 reset = 1'b1;
    #1 chk("arst_r5", readData1, 32'h0);
    chk("arst_busy9", {31'b0, busy2}, 32'h0);
    chk("arst_clrbusy", {31'b0, clearBusy}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Load r1..r31
    for (int i = 1; i < 32; i++) begin
      regWrite = 1; writeAddr = i[4:0]; writeData = i * 32'h01010101;
      tick();
    end
    regWrite = 0; readAddr1 = 31; readAddr2 = 20;
    #1 chk("load_r31", readData1, 32'h1F1F1F1F);
    chk("load_r20", readData2, 32'h14141414);
    issueValid = 1; issueAddr = 9;
    tick();
    issueValid = 0; readAddr2 = 9;
    #1 chk("pre_sweep_busy9", {31'b0, busy2}, 32'h1);

    // Clear sweep
    clearReq = 1;
    tick();
    clearReq = 0;
    n = 0;
    while (clearBusy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) chk("sweep_flush_busy9", {31'b0, busy2}, 32'h0);
      if (n == 3) begin
        regWrite = 1; writeAddr = 1; writeData = 32'h5555;
        issueValid = 1; issueAddr = 9; readAddr1 = 1;
        #1 chk("sweep_no_byp", readData1, 32'h0);
      end else begin
        regWrite = 0; issueValid = 0;
      end
      tick();
    end
    regWrite = 0; issueValid = 0;
    chk("sweep_len", n, 32);
    chk("done_pulse", {31'b0, clearDone}, 32'h1);
    tick();
    chk("done_gone", {30'b0, clearDone, clearBusy}, 32'h0);
    chk("post_busy9", {31'b0, busy2}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      readAddr1 = i[4:0];
      tick();
      chk($sformatf("swept_r%0d", i), readData1, 32'h0);
    end

    // Narrow instance: 16-bit data, 8-entry sweep
    s_regWrite = 1; s_writeAddr = 7; s_writeData = 16'hFFFF;
    tick();
    s_regWrite = 0; s_readAddr1 = 7;
    #1 chk("s_r7", {16'h0, s_readData1}, 32'h0000FFFF);
    s_clearReq = 1;
    tick();
    s_clearReq = 0;
    n = 0;
    while (s_clearBusy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("s_sweep_len", n, 8);
    chk("s_done_pulse", {31'b0, s_clearDone}, 32'h1);
    chk("s_r7_swept", {16'h0, s_readData1}, 32'h0);

    // Reset aborts a sweep in progress
    clearReq = 1;
    tick();
    clearReq = 0;
    tick();
    tick();
    chk("midsweep_busy", {31'b0, clearBusy}, 32'h1);
    #1 reset = 1'b1;
    #1 chk("midsweep_arst", {30'b0, clearBusy, clearDone}, 32'h0);
    reset = 1'b0;
    tick();
    chk("midsweep_idle", {30'b0, clearBusy, clearDone}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
